// File: rtl/e203_pad_pwr_seq.sv
// e203_pad_pwr_seq: AON pad ring power sequencer (pad VDD enable, pad reset, output isolation).
// Latency: outputs registered and aligned with the state register; wake to VDD = 2 sync + DEB_CYC cycles.
// Backpressure: none; sleep_req_i in RAMP is held pending, and is ignored in ISO/DOWN/OFF.
// Optional: define E203_PAD_PWR_TEST_MODE_EN to add test_mode_i, which forces the ON state.
module e203_pad_pwr_seq #(
  parameter int unsigned RAMP_CYC = 64,
  parameter int unsigned HOLD_CYC = 8,
  parameter int unsigned DEB_CYC  = 16,
  parameter int unsigned CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       dwakeup_n_i,
  input  logic       sleep_req_i,
`ifdef E203_PAD_PWR_TEST_MODE_EN
  input  logic       test_mode_i,
`endif
  output logic       sleep_ack_o,
  output logic       wake_evt_o,
  output logic       vddpaden_o,
  output logic       padrst_o,
  output logic       pad_iso_o,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    ST_RAMP = 3'd0,
    ST_ON   = 3'd1,
    ST_ISO  = 3'd2,
    ST_DOWN = 3'd3,
    ST_OFF  = 3'd4
  } state_e;

  localparam logic [CNT_W-1:0] RAMP_LD  = CNT_W'(RAMP_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYC - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] deb_cnt_q, deb_cnt_d;
  logic             pend_q, pend_d;
  logic             wake_evt_q, wake_evt_d;
  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             vddpaden_q, vddpaden_d;
  logic             padrst_q, padrst_d;
  logic             pad_iso_q, pad_iso_d;
  logic             sleep_ack_q, sleep_ack_d;

  // Next-state, counters, debounce and output decode of the next state.
  always_comb begin
    sync1_d    = dwakeup_n_i;
    sync2_d    = sync1_q;
    state_d    = state_q;
    cnt_d      = cnt_q;
    pend_d     = pend_q;
    deb_cnt_d  = '0;
    wake_evt_d = 1'b0;

    case (state_q)
      ST_RAMP: begin
        // A request during ramp is remembered and served on the first ON cycle.
        if (sleep_req_i) pend_d = 1'b1;
        if (cnt_q == '0) state_d = ST_ON;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ST_ON: begin
        if (pend_q || sleep_req_i) begin
          state_d = ST_ISO;
          pend_d  = 1'b0;
        end
      end
      ST_ISO: begin
        state_d = ST_DOWN;
        cnt_d   = HOLD_LD;
      end
      ST_DOWN: begin
        // Shutdown always completes; the wake pin is not looked at here.
        if (cnt_q == '0) state_d = ST_OFF;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ST_OFF: begin
        if (!sync2_q) begin
          if (deb_cnt_q == DEB_LAST) begin
            state_d    = ST_RAMP;
            cnt_d      = RAMP_LD;
            wake_evt_d = 1'b1;
            pend_d     = 1'b0;
          end else if (deb_cnt_q != '1) begin
            deb_cnt_d = deb_cnt_q + 1'b1;
          end else begin
            deb_cnt_d = deb_cnt_q;
          end
        end
      end
      default: begin
        state_d = ST_RAMP;
        cnt_d   = RAMP_LD;
        pend_d  = 1'b0;
      end
    endcase

`ifdef E203_PAD_PWR_TEST_MODE_EN
    if (test_mode_i) begin
      state_d    = ST_ON;
      cnt_d      = cnt_q;
      pend_d     = 1'b0;
      deb_cnt_d  = '0;
      wake_evt_d = 1'b0;
    end
`endif

    // Outputs decode the next state so the registered copies line up with state_q.
    vddpaden_d  = 1'b1;
    padrst_d    = 1'b1;
    pad_iso_d   = 1'b1;
    sleep_ack_d = 1'b0;
    case (state_d)
      ST_ON:   begin padrst_d = 1'b0; pad_iso_d = 1'b0; end
      ST_ISO:  begin padrst_d = 1'b0; end
      ST_OFF:  begin vddpaden_d = 1'b0; sleep_ack_d = 1'b1; end
      default: begin end
    endcase
  end

  // All sequencer state, synchronizer and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      state_q     <= ST_RAMP;
      cnt_q       <= RAMP_LD;
      pend_q      <= 1'b0;
      deb_cnt_q   <= '0;
      wake_evt_q  <= 1'b0;
      vddpaden_q  <= 1'b1;
      padrst_q    <= 1'b1;
      pad_iso_q   <= 1'b1;
      sleep_ack_q <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      deb_cnt_q   <= deb_cnt_d;
      wake_evt_q  <= wake_evt_d;
      vddpaden_q  <= vddpaden_d;
      padrst_q    <= padrst_d;
      pad_iso_q   <= pad_iso_d;
      sleep_ack_q <= sleep_ack_d;
    end
  end

  assign sleep_ack_o = sleep_ack_q;
  assign wake_evt_o  = wake_evt_q;
  assign vddpaden_o  = vddpaden_q;
  assign padrst_o    = padrst_q;
  assign pad_iso_o   = pad_iso_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_e203_pad_pwr_seq.sv
// Scoreboard bench for e203_pad_pwr_seq: expected output vectors are queued per cycle
// by the stimulus process, and a negedge monitor pops and compares them; wake pulses
// are checked against a separate queue of expected wake cycles.
module tb_e203_pad_pwr_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       dwakeup_n_i;
  logic       sleep_req_i;
`ifdef E203_PAD_PWR_TEST_MODE_EN
  logic       test_mode_i;
`endif
  logic       sleep_ack_o;
  logic       wake_evt_o;
  logic       vddpaden_o;
  logic       padrst_o;
  logic       pad_iso_o;
  logic [2:0] state_o;

  // {state[2:0], vddpaden, padrst, iso, ack, wake_evt}
  localparam logic [7:0] V_RAMP  = 8'b0001_1100;
  localparam logic [7:0] V_RAMPW = 8'b0001_1101;
  localparam logic [7:0] V_ON    = 8'b0011_0000;
  localparam logic [7:0] V_ISO   = 8'b0101_0100;
  localparam logic [7:0] V_DOWN  = 8'b0111_1100;
  localparam logic [7:0] V_OFF   = 8'b1000_1110;

  e203_pad_pwr_seq #(
    .RAMP_CYC(64), .HOLD_CYC(8), .DEB_CYC(16), .CNT_W(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .dwakeup_n_i(dwakeup_n_i),
    .sleep_req_i(sleep_req_i),
`ifdef E203_PAD_PWR_TEST_MODE_EN
    .test_mode_i(test_mode_i),
`endif
    .sleep_ack_o(sleep_ack_o),
    .wake_evt_o(wake_evt_o),
    .vddpaden_o(vddpaden_o),
    .padrst_o(padrst_o),
    .pad_iso_o(pad_iso_o),
    .state_o(state_o)
  );

  initial forever #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         q_cyc[$];
  logic [7:0] q_exp[$];
  string      q_name[$];
  int         wq[$];
  int         n_cmp = 0;
  int         n_err = 0;
  int         wake_seen = 0;
  logic [7:0] obs;
  logic       done = 1'b0;
  logic       fin = 1'b0;

  // Queue an expected output vector for cycle cyc+d, keeping the queue ordered.
  task automatic push(input int d, input logic [7:0] v, input string n);
    int at;
    int i;
    at = cyc + d;
    i = 0;
    while (i < q_cyc.size() && q_cyc[i] <= at) i++;
    q_cyc.insert(i, at);
    q_exp.insert(i, v);
    q_name.insert(i, n);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: compare every queued vector due this cycle, and every wake pulse.
  always @(negedge clk) begin
    obs = {state_o, vddpaden_o, padrst_o, pad_iso_o, sleep_ack_o, wake_evt_o};
    while (q_cyc.size() > 0 && q_cyc[0] <= cyc) begin
      n_cmp++;
      if (q_cyc[0] != cyc || obs !== q_exp[0]) begin
        n_err++;
        $display("FAIL %s cycle %0d: got %b, expected %b (due cycle %0d)",
                 q_name[0], cyc, obs, q_exp[0], q_cyc[0]);
      end
      void'(q_cyc.pop_front());
      void'(q_exp.pop_front());
      void'(q_name.pop_front());
    end
    if (wake_evt_o === 1'b1) begin
      wake_seen++;
      n_cmp++;
      if (wq.size() == 0 || wq[0] != cyc) begin
        n_err++;
        $display("FAIL wake_evt cycle %0d: got pulse, expected at %0d",
                 cyc, (wq.size() == 0) ? -1 : wq[0]);
      end else begin
        void'(wq.pop_front());
      end
    end
    if (done && !fin) begin
      while (q_cyc.size() > 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL %s never checked: expected %b at cycle %0d", q_name[0], q_exp[0], q_cyc[0]);
        void'(q_cyc.pop_front());
        void'(q_exp.pop_front());
        void'(q_name.pop_front());
      end
      n_cmp++;
      if (wake_seen != 2 || wq.size() != 0) begin
        n_err++;
        $display("FAIL wake_count: got %0d pulses, expected 2 (%0d outstanding)", wake_seen, wq.size());
      end
      fin = 1'b1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int b, c, d, e;
    rst = 1'b1;
    dwakeup_n_i = 1'b1;
    sleep_req_i = 1'b0;
`ifdef E203_PAD_PWR_TEST_MODE_EN
    test_mode_i = 1'b0;
`endif
    step(2);
    // Reset state and power-up ramp.
    push(0,  V_RAMP, "reset_state");
    push(1,  V_RAMP, "ramp_first");
    push(63, V_RAMP, "ramp_last");
    push(64, V_ON,   "ramp_to_on");
    rst = 1'b0;
    step(64);

    // Sleep from ON: ISO 1 cycle, DOWN 8 cycles, OFF; a sleep pulse in OFF is ignored.
    b = cyc;
    push(1,  V_ISO,  "iso_1cyc");
    push(2,  V_DOWN, "down_first");
    push(9,  V_DOWN, "down_last");
    push(10, V_OFF,  "off_entry");
    push(13, V_OFF,  "off_sleep_ignored");
    sleep_req_i = 1'b1;
    step(1);
    sleep_req_i = 1'b0;
    step(10);
    sleep_req_i = 1'b1;
    step(1);
    sleep_req_i = 1'b0;
    step(1);

    // Short 10-cycle low pulse must not wake.
    c = cyc;
    push(5,  V_OFF, "short_pulse_a");
    push(12, V_OFF, "short_pulse_b");
    push(18, V_OFF, "short_pulse_c");
    push(24, V_OFF, "short_pulse_d");
    dwakeup_n_i = 1'b0;
    step(10);
    dwakeup_n_i = 1'b1;
    step(15);

    // Long low pulse wakes 18 cycles after the falling edge; sleep at RAMP cycle 5 is pended.
    d = cyc;
    push(17, V_OFF,   "pre_wake_off");
    push(18, V_RAMPW, "wake_ramp");
    push(19, V_RAMP,  "wake_single_pulse");
    push(81, V_RAMP,  "pend_ramp_last");
    push(82, V_ON,    "pend_on_1cyc");
    push(83, V_ISO,   "pend_iso");
    push(84, V_DOWN,  "pend_down");
    push(91, V_DOWN,  "pend_down_last");
    push(92, V_OFF,   "pend_off");
    wq.push_back(d + 18);
    dwakeup_n_i = 1'b0;
    step(20);
    dwakeup_n_i = 1'b1;
    step(3);
    sleep_req_i = 1'b1;
    step(1);
    sleep_req_i = 1'b0;
    step(70);

    // Wake again, sleep, then reset in the middle of DOWN.
    e = cyc;
    push(17,  V_OFF,   "wake2_off");
    push(18,  V_RAMPW, "wake2_ramp");
    push(82,  V_ON,    "wake2_on");
    push(83,  V_ISO,   "wake2_iso");
    push(86,  V_DOWN,  "rst_pre_down");
    push(87,  V_RAMP,  "rst_in_down");
    push(88,  V_RAMP,  "rst_ramp_next");
    push(150, V_RAMP,  "rst_ramp_last");
    push(151, V_ON,    "rst_ramp_on");
    wq.push_back(e + 18);
    dwakeup_n_i = 1'b0;
    step(20);
    dwakeup_n_i = 1'b1;
    step(62);
    sleep_req_i = 1'b1;
    step(1);
    sleep_req_i = 1'b0;
    step(3);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    step(64);

`ifdef E203_PAD_PWR_TEST_MODE_EN
    // Test mode from OFF forces ON; sleep requests are ignored meanwhile.
    push(12, V_OFF, "tm_pre_off");
    push(13, V_ON,  "tm_force_on");
    push(14, V_ON,  "tm_sleep_ignored");
    push(16, V_ON,  "tm_hold_on");
    push(17, V_ON,  "tm_release_on");
    sleep_req_i = 1'b1;
    step(1);
    sleep_req_i = 1'b0;
    step(11);
    test_mode_i = 1'b1;
    step(1);
    sleep_req_i = 1'b1;
    step(1);
    sleep_req_i = 1'b0;
    step(2);
    test_mode_i = 1'b0;
    step(1);
`endif

    step(3);
    done = 1'b1;
    for (int k = 0; k < 5 && !fin; k++) begin
      @(negedge clk);
      #1;
    end
    if (!fin) begin
      n_cmp++;
      n_err++;
      $display("FAIL final_check: got no final report, expected one");
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/e203_pad_pwr_seq.md
Name: e203_pad_pwr_seq

Overview:
- Sequences the always-on pad ring power and reset signals: pad VDD enable, pad reset and output isolation.
- Sits beside the PMU in the AON domain and drives the padrst/vddpaden outputs that leave the chip through output pad cells.
- Powers pads up after reset or after a debounced wake-up pin event.
- Powers pads down on a sleep request, in a glitch-free order: isolate, then reset, then VDD off.

Parameters:
- RAMP_CYC, 64: cycles VDD is held on with pad reset asserted before release (legal 1..2^CNT_W-1).
- HOLD_CYC, 8: cycles pad reset is held before VDD is removed at shutdown (legal 1..2^CNT_W-1).
- DEB_CYC, 16: consecutive synchronized-low cycles on the wake pin required to wake (legal 1..2^CNT_W-1).
- CNT_W, 8: width of the shared state counter and the debounce counter.

Ports:
- clk  input  1  AON clock.
- rst  input  1  synchronous, active-high reset; one clock; all flops reset on the rising clk edge while rst=1.
- dwakeup_n_i  input  1  asynchronous wake pin from the pad, active low.
- sleep_req_i  input  1  single-cycle sleep request pulse from the PMU.
- sleep_ack_o  output  1  high while pads are fully powered down (state OFF).
- wake_evt_o  output  1  one-cycle pulse when a debounced wake is accepted.
- vddpaden_o  output  1  pad VDD enable.
- padrst_o  output  1  pad reset, active high.
- pad_iso_o  output  1  pad output isolation, active high.
- state_o  output  3  current FSM state encoding, for debug.

Behaviour:
- Wake pin synchronizer: 2-flop synchronizer, flops reset to 1.
- States and encoding: RAMP=0, ON=1, ISO=2, DOWN=3, OFF=4.
- Outputs by state (vddpaden/padrst/iso/ack):
  - RAMP 1/1/1/0
  - ON 1/0/0/0
  - ISO 1/0/1/0
  - DOWN 1/1/1/0
  - OFF 0/1/1/1
- All outputs are registered and decoded from the state register.
- Reset: state=RAMP, cnt=RAMP_CYC-1, pend=0, deb_cnt=0, wake_evt_o=0.
  - Output values during and just after reset are therefore vddpaden=1, padrst=1, iso=1, ack=0, state_o=0.
- RAMP:
  - cnt decrements each cycle; at cnt==0 go to ON.
  - RAMP lasts exactly RAMP_CYC cycles.
- ON:
  - If pend=1 or sleep_req_i=1, go to ISO and clear pend.
  - ISO lasts exactly 1 cycle, then go to DOWN with cnt=HOLD_CYC-1.
- DOWN: cnt decrements; at cnt==0 go to OFF.
- Pending sleep request:
  - A sleep_req_i pulse arriving in RAMP sets pend; it is taken on the first ON cycle, so ON lasts 1 cycle.
  - sleep_req_i pulses in ISO, DOWN or OFF are ignored.
- Debounce:
  - deb_cnt is active only in OFF; it is cleared in every other state.
  - In OFF, a synchronized low increments deb_cnt (saturating); a synchronized high clears it.
  - When deb_cnt reaches DEB_CYC-1 with the pin still low: go to RAMP, load cnt=RAMP_CYC-1, pulse wake_evt_o for 1 cycle (registered, coincident with the first RAMP cycle), clear deb_cnt and pend.
- A wake pin held low during DOWN does not abort the shutdown.
  - The sequence completes to OFF; debounce then starts from 0.
- Wake-to-VDD latency from the first low pin sample: 2 (sync) + DEB_CYC cycles.
- Reset mid-sequence (any state): returns immediately to RAMP with reset values. VDD is re-enabled on the next edge.
- Illegal state encodings (5..7) go to RAMP.

Optional Feature:
- Macro: E203_PAD_PWR_TEST_MODE_EN.
- Defined:
  - Adds input test_mode_i (1 bit).
  - While test_mode_i=1, the next state is forced to ON from any state, and pend and deb_cnt are held at 0.
  - Outputs follow ON (1/0/0/0) from the next cycle, and sleep_req_i is ignored.
  - On test_mode_i falling, normal operation resumes from ON.
- Undefined: the port is absent and the logic is removed.

Test Plan:
1. Release reset, defaults, sleep_req_i=0, wake pin high -> vddpaden=1 and padrst=1 for 64 cycles; padrst=0 and iso=0 on cycle 64; state_o=1.
2. In ON, pulse sleep_req_i -> ISO (iso=1) for 1 cycle, DOWN (padrst=1) for 8 cycles, then OFF with vddpaden=0 and sleep_ack_o=1.
3. In OFF, drive wake pin low for 10 cycles then high, then low for 20 cycles:
   - The 10-cycle pulse produces no wake.
   - The 20-cycle pulse produces one wake_evt_o pulse 18 cycles after the low edge, state RAMP, vddpaden=1.
4. Pulse sleep_req_i at RAMP cycle 5 -> ON lasts 1 cycle, then the ISO/DOWN/OFF sequence runs.
5. Assert rst for 1 cycle during DOWN -> next cycle state_o=0, vddpaden=1, padrst=1, sleep_ack_o=0.
6. With E203_PAD_PWR_TEST_MODE_EN defined: test_mode_i=1 in OFF -> next cycle vddpaden=1, padrst=0, iso=0; a sleep_req_i pulse has no effect.
